dispatch_buffer: RTL and testbench
==================================

DISPATCH_BUFFER -- requirements
Module: dispatch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the entry count; legal values are powers of two from 2 to 16.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 flush  input  1  SHALL discard all held entries (misprediction recovery).
REQ-005 valid_in  input  1  SHALL mark data_in as valid from rename.
REQ-006 ready_in  output  1  SHALL indicate the buffer accepts an entry this cycle.
REQ-007 data_in  input  dispatch_pipeline_data  SHALL carry Opcode, prd, pr1, pr2, imm, rob_index and fu.
REQ-008 valid_out  output  1  SHALL mark data_out as valid toward the ALU reservation station.
REQ-009 ready_out  input  1  SHALL be the reservation station's accept signal (its ready_in).
REQ-010 data_out  output  dispatch_pipeline_data  SHALL be the oldest held entry.
REQ-011 count  output  $clog2(DEPTH)+1  SHALL report the number of held entries.

Function
REQ-012 Push SHALL occur when valid_in && ready_in; pop SHALL occur when valid_out && ready_out.
REQ-013 ready_in SHALL equal (count != DEPTH) and SHALL NOT depend combinationally on ready_out or valid_in.
REQ-014 valid_out SHALL equal (count != 0); data_out SHALL be the entry at the head (first-word fall-through).
REQ-015 A push into an empty buffer SHALL appear on valid_out/data_out the following cycle; there is no same-cycle bypass.
REQ-016 Storage SHALL be circular, with head and tail pointers of $clog2(DEPTH) bits wrapping from DEPTH-1 to 0.
REQ-017 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-018 When full, a push SHALL be impossible even if a pop occurs in the same cycle.
REQ-019 When empty, ready_out SHALL have no effect and head SHALL NOT move.
REQ-020 Entries SHALL leave in exact arrival order, with all data_in fields preserved bit-exact.
REQ-021 data_out SHALL hold stable while valid_out=1 and ready_out=0.
REQ-022 On flush, head, tail and count SHALL be 0 the next cycle.
REQ-023 flush SHALL override a push or pop in the same cycle: no entry is written and no handshake is counted.
REQ-024 During a flush cycle, ready_in SHALL still reflect the pre-flush count, and the upstream SHALL treat a flushed push as dropped.
REQ-025 Entry storage SHALL NOT be cleared by flush or reset; only pointers and count are cleared.

Reset
REQ-026 On reset, head, tail and count SHALL be 0, so valid_out=0 and ready_in=1 on the first cycle after reset.
REQ-027 Reset asserted mid-operation SHALL discard all entries with priority over flush, push and pop.
REQ-028 data_out SHALL be don't-care while valid_out=0.

Structure
REQ-029 dispatch_pipeline_data SHALL stay defined in types_pkg; no new typedef is added.
REQ-030 A DISPATCH_BUF_DEPTH constant SHALL be added to types_pkg, and the instantiating top SHALL use it for DEPTH.
REQ-031 The block SHALL be a single module with no sub-modules; storage SHALL be a register array indexed by the pointers.

Verification
REQ-032 Reset, then push 1 entry (rob_index=3) with ready_out=0 -> next cycle valid_out=1, data_out.rob_index=3, count=1, held stable for 5 cycles.
REQ-033 Push rob_index 0..3 with ready_out=0 -> count=4, ready_in=0; a fifth valid_in is not accepted; then hold ready_out=1 -> outputs 0,1,2,3 in order on consecutive cycles.
REQ-034 Hold count=2, then continuous valid_in and ready_out for 10 cycles -> count stays 2, pointers wrap, and output order matches input order with imm values 0x100..0x109.
REQ-035 Full buffer with ready_out=1 and valid_in=1 -> one pop, no push, count=3, ready_in=1 the next cycle.
REQ-036 count=3 with flush=1, valid_in=1 and ready_out=1 in the same cycle -> next cycle count=0, valid_out=0, ready_in=1, and no entry is emitted later.
REQ-037 Reset asserted at count=2 together with a push -> next cycle count=0, valid_out=0.

Source files
------------

// File: rtl/types_pkg.sv
// Shared pipeline types: the rename-to-dispatch payload and the dispatch buffer depth.
package types_pkg;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_LSU = 2'd2,
    FU_BR  = 2'd3
  } fu_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [5:0]  prd;
    logic [5:0]  pr1;
    logic [5:0]  pr2;
    logic [31:0] imm;
    logic [3:0]  rob_index;
    fu_e         fu;
  } dispatch_pipeline_data;

  // Entry count used wherever a dispatch_buffer is instantiated; power of two, 2..16.
  localparam int DISPATCH_BUF_DEPTH = 4;

endpackage

// File: rtl/dispatch_buffer.sv
// Circular first-word-fall-through buffer between rename and the ALU reservation station.
module dispatch_buffer
  import types_pkg::*;
#(
  parameter int DEPTH = DISPATCH_BUF_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  dispatch_pipeline_data   data_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output dispatch_pipeline_data   data_out,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // ready_in depends only on the registered count, never on valid_in or ready_out,
  // so a full buffer refuses a push even when it pops in the same cycle.
  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  dispatch_pipeline_data  mem [DEPTH];
  logic                   push;
  logic                   pop;

  assign ready_in  = (count != CW'(DEPTH));
  assign valid_out = (count != '0);
  assign data_out  = mem[head];

  assign push = valid_in && ready_in;
  assign pop  = valid_out && ready_out;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage is never cleared; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[tail] <= data_in;
  end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Bench for dispatch_buffer: directed scenarios followed by random traffic, checked against a queue model.
module tb_dispatch_buffer;
  import types_pkg::*;

  localparam int DEPTH = DISPATCH_BUF_DEPTH;
  localparam int W     = $bits(dispatch_pipeline_data);

  logic                   clk;
  logic                   reset;
  logic                   flush;
  logic                   valid_in;
  logic                   ready_in;
  dispatch_pipeline_data  data_in;
  logic                   valid_out;
  logic                   ready_out;
  dispatch_pipeline_data  data_out;
  logic [$clog2(DEPTH):0] count;
  logic [W-1:0]           data_out_bits;

  assign data_out_bits = data_out;

  dispatch_buffer #(.DEPTH(DISPATCH_BUF_DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out),
    .count     (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           m_count;
  int           checks;
  int           failures;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic dispatch_pipeline_data mk(input int rob, input int imm);
    dispatch_pipeline_data it;
    it.opcode    = 7'($urandom);
    it.prd       = 6'($urandom);
    it.pr1       = 6'($urandom);
    it.pr2       = 6'($urandom);
    it.imm       = 32'(imm);
    it.rob_index = 4'(rob);
    it.fu        = fu_e'($urandom_range(0, 3));
    return it;
  endfunction

  // driver: apply one cycle of inputs, check outputs against the model, then advance the model
  task automatic step(input logic v, input dispatch_pipeline_data d, input logic r,
                      input logic f, input logic rst);
    logic do_push;
    logic do_pop;
    valid_in  = v;
    data_in   = d;
    ready_out = r;
    flush     = f;
    reset     = rst;
    #1;
    check_eq("count", 64'(count), 64'(m_count));
    check_eq("valid_out", 64'(valid_out), 64'(m_count != 0));
    check_eq("ready_in", 64'(ready_in), 64'(m_count != DEPTH));
    if (m_count != 0) check_eq("data_out", 64'(data_out_bits), 64'(exp_q[0]));
    do_pop  = r && (m_count != 0);
    do_push = v && (m_count != DEPTH);
    @(posedge clk);
    #1;
    if (rst || f) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(d);
    end
    m_count = exp_q.size();
  endtask

  task automatic idle(input logic r);
    step(1'b0, mk(0, 0), r, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    m_count   = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    data_in   = '0;
    repeat (2) @(posedge clk);
    #1;

    // first cycle after reset: empty and accepting
    idle(1'b0);

    // single push held at the head for five cycles
    step(1'b1, mk(3, 32'h33), 1'b0, 1'b0, 1'b0);
    check_eq("single_rob", 64'(data_out.rob_index), 64'd3);
    for (int i = 0; i < 5; i++) idle(1'b0);
    drain();

    // fill to full, refused fifth push, then in-order drain
    for (int i = 0; i < 4; i++) step(1'b1, mk(i, i), 1'b0, 1'b0, 1'b0);
    check_eq("full_ready_in", 64'(ready_in), 64'd0);
    step(1'b1, mk(4, 4), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_rob", 64'(data_out.rob_index), 64'(i));
      idle(1'b1);
    end
    idle(1'b0);

    // steady state at count 2 with pointers wrapping
    step(1'b1, mk(5, 32'h0fe), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(6, 32'h0ff), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, mk(i, 32'h100 + i), 1'b1, 1'b0, 1'b0);
    check_eq("steady_count", 64'(count), 64'd2);
    check_eq("steady_imm", 64'(data_out.imm), 64'h108);
    drain();

    // full buffer: pop but no push in the same cycle
    for (int i = 0; i < 4; i++) step(1'b1, mk(i + 8, i), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(12, 12), 1'b1, 1'b0, 1'b0);
    check_eq("full_pop_count", 64'(count), 64'd3);
    check_eq("full_pop_ready", 64'(ready_in), 64'd1);

    // flush at count 3 overrides simultaneous push and pop
    step(1'b1, mk(13, 13), 1'b1, 1'b1, 1'b0);
    check_eq("flush_count", 64'(count), 64'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // reset at count 2 together with a push
    step(1'b1, mk(1, 1), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(2, 2), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(3, 3), 1'b1, 1'b0, 1'b1);
    check_eq("reset_count", 64'(count), 64'd0);
    idle(1'b1);

    // random traffic with occasional flush and reset
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), mk($urandom_range(0, 15), $urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 63) == 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
